// File: rtl/mmio_console_tx.sv
// Memory-mapped UART 8N1 console transmitter: a CPU store pushes a byte into a FIFO, and a serializer drains it onto tx.
// Optional macro MMIO_CONSOLE_TX_COUNT_EN exports the FIFO count in STATUS[15:8].
module mmio_console_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        port2isStore,
  input  logic [31:0] inw,
  output logic        hit,
  output logic [31:0] outw,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  logic            w_full;
  logic            w_empty;
  logic            w_busy;
  logic            w_wr_tx;
  logic            w_wr_st;
  logic            w_push_ok;
  logic            w_push_rej;
  logic            w_ovf_clr;
  logic            w_baud_end;
  logic            w_pop;
  logic [7:0]      w_rd_data;
  logic [7:0]      w_cnt_field;
  logic [31:0]     w_status;
  logic            w_unused_bits;

  assign hit        = (address[31:3] == BASE_ADDR[31:3]);
  assign w_wr_tx    = hit && port2isStore && !address[2];
  assign w_wr_st    = hit && port2isStore && address[2];
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push_ok  = w_wr_tx && !w_full;
  assign w_push_rej = w_wr_tx && w_full;
  assign w_ovf_clr  = w_wr_st && inw[3];
  assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));
  // Pops come only from IDLE or the last cycle of STOP, and only against the registered count.
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));
  assign w_rd_data  = r_mem[r_rd_ptr];
  assign w_unused_bits = &{1'b0, address[1:0], inw[31:8]};

`ifdef MMIO_CONSOLE_TX_COUNT_EN
  assign w_cnt_field = 8'(r_count);
`else
  assign w_cnt_field = 8'h00;
`endif

  assign w_status = {16'h0000, w_cnt_field, 4'h0, r_ovf, w_busy, w_empty, w_full};
  assign outw     = (hit && address[2]) ? w_status : '0;
  assign tx       = r_tx;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= inw[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_clr)       r_ovf <= 1'b0;
      else if (w_push_rej) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_rd_data;
            r_baud  <= '0;
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_rd_data;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_console_tx.sv
// Directed bench for mmio_console_tx: bytes are queued as they are stored and checked as a monitor decodes tx frames.
module tb_mmio_console_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STS  = BASE + 32'd4;
  localparam int unsigned CPB  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        port2isStore;
  logic [31:0] inw;
  logic        hit;
  logic [31:0] outw;
  logic        tx;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  q[$];
  int unsigned starts[$];
  bit          mon_en;
  logic [7:0]  mb;
  bit          mv;
  int unsigned ms;
  int unsigned t0;
  bit          bad;

  mmio_console_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .port2isStore(port2isStore),
    .inw         (inw),
    .hit         (hit),
    .outw        (outw),
    .tx          (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(int n);
`ifdef MMIO_CONSOLE_TX_COUNT_EN
    return 32'(n) << 8;
`else
    return 32'(0) & 32'(n);
`endif
  endfunction

  task automatic store(logic [31:0] a, logic [31:0] d);
    address      = a;
    inw          = d;
    port2isStore = 1'b1;
    @(posedge clk); #1;
    port2isStore = 1'b0;
  endtask

  task automatic send(logic [7:0] b);
    q.push_back(b);
    store(TXD, {24'h0, b});
  endtask

  task automatic chk_status(string tag, logic [31:0] exp);
    address = STS;
    @(negedge clk);
    chk(tag, outw, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(string tag, int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk(tag, q.size(), 0);
  endtask

  task automatic chk_contig(string tag, int n);
    chk({tag, "_frames"}, starts.size(), n);
    for (int i = 1; i < starts.size(); i++)
      chk({tag, "_gap"}, starts[i] - starts[i-1], 10 * CPB);
  endtask

  // Frame decoder: samples each bit near its centre and compares against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        ms = cyc;
        mv = 1'b1;
        @(negedge clk);
        mv &= mon_en;
        if (mv) chk("start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mb[i] = tx;
          mv &= mon_en;
        end
        repeat (CPB) @(negedge clk);
        mv &= mon_en;
        if (mv) begin
          chk("stop_bit", tx, 1);
          starts.push_back(ms);
          chk("frame_expected", q.size() != 0, 1);
          if (q.size() != 0) chk("frame_byte", mb, q.pop_front());
        end
        repeat (CPB / 2) @(negedge clk);
      end
    end
  end

  initial begin
    reset = 1'b1; address = '0; inw = '0; port2isStore = 1'b0; mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset_tx", tx, 1);
    @(posedge clk); #1;
    chk_status("reset_status", 32'h2);
    address = BASE + 32'd8;
    @(negedge clk);
    chk("miss_hit", hit, 0);
    chk("miss_outw", outw, 0);
    address = TXD;
    @(negedge clk);
    chk("txdata_hit", hit, 1);
    chk("txdata_load", outw, 0);
    @(posedge clk); #1;

    // single byte: latency, bit pattern, end of busy
    starts.delete();
    t0 = cyc;
    send(8'hA5);
    repeat (40) @(posedge clk);
    #1;
    chk_status("a5_last_stop", 32'h6 | cnt(0));
    chk_status("a5_idle", 32'h2);
    chk("a5_frames", starts.size(), 1);
    if (starts.size() != 0) chk("a5_latency", starts[0] - t0, 2);
    chk("a5_drained", q.size(), 0);

    // nine back-to-back stores, then overflow and clear
    starts.delete();
    for (int i = 0; i < 9; i++) send(8'h30 + 8'(i));
    store(TXD, 32'h0000_00EE);
    chk_status("full_ovf", 32'hD | cnt(8));
    store(STS, 32'h0000_0008);
    chk_status("ovf_clear", 32'h5 | cnt(8));
    wait_drain("nine_drain", 800);
    chk_status("nine_idle", 32'h2);
    chk_contig("nine", 9);

    // three queued bytes: count field and contiguous frames
    starts.delete();
    send(8'hC3); send(8'h3C); send(8'h81);
    chk_status("three_count", 32'h4 | cnt(2));
    wait_drain("three_drain", 400);
    chk_contig("three", 3);

    // reset in the middle of DATA with two bytes still queued
    send(8'h55); send(8'hAA); send(8'h0F);
    repeat (12) @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    reset  = 1'b0;
    @(negedge clk);
    chk("reset_mid_tx", tx, 1);
    q.delete();
    @(posedge clk); #1;
    chk_status("reset_mid_status", 32'h2);
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    chk("reset_no_frames", bad, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
